// File: rtl/vending_machine_change.sv
// Coin-operated vending controller with programmable price.
// Accumulates nickel/dime/quarter credit, dispenses one item when the price
// is reached, then pays back any overpayment one nickel per cycle. A cancel
// request in COLLECT refunds the whole credit the same way. A saturating
// counter tracks completed sales.
module vending_machine_change #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                cancel,
  output logic                newspaper,
  output logic                change_n,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    sold_count
);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  // The running sum is one bit wider than the credit register so the
  // comparison against the price can never wrap.
  localparam logic [CREDIT_W:0]   PRICE_S = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] ZERO_C  = '0;

  // Value of a single accepted coin; caller guarantees exactly one strobe.
  function automatic logic [CREDIT_W:0] coin_value(input logic n,
                                                   input logic d,
                                                   input logic q);
    logic [CREDIT_W:0] v;
    v = '0;
    if (n) v = (CREDIT_W + 1)'(5);
    if (d) v = (CREDIT_W + 1)'(10);
    if (q) v = (CREDIT_W + 1)'(25);
    return v;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  state_t              state;
  state_t              state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [1:0]          strobe_cnt;
  logic                any_strobe;
  logic                coin_valid;
  logic                coin_bad;
  logic [CREDIT_W:0]   sum;
  logic                sale;

  // Classify this cycle's coin strobes as accepted or rejected.
  always_comb begin
    strobe_cnt = 2'(N) + 2'(D) + 2'(Q);
    any_strobe = N | D | Q;
    coin_valid = (strobe_cnt == 2'd1) && (state == COLLECT) && !cancel;
    coin_bad   = any_strobe && !coin_valid;
    sum        = {1'b0, credit} + coin_value(N, D, Q);
  end

  // Next-state and next-credit decision for the controller.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    sale       = 1'b0;
    unique case (state)
      COLLECT: begin
        if (coin_valid) begin
          if (sum >= PRICE_S) begin
            credit_nxt = CREDIT_W'(sum - PRICE_S);
            state_nxt  = DISPENSE;
            sale       = 1'b1;
          end else begin
            credit_nxt = CREDIT_W'(sum);
          end
        end else if (cancel && (credit != ZERO_C)) begin
          // Full refund: the change loop drains whatever credit is held.
          state_nxt = CHANGE;
        end
      end
      DISPENSE: begin
        state_nxt = (credit != ZERO_C) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        // Each cycle here pays out one nickel; leave on the last one.
        if (credit <= NICKEL) begin
          credit_nxt = ZERO_C;
          state_nxt  = COLLECT;
        end else begin
          credit_nxt = credit - NICKEL;
        end
      end
      default: begin
        state_nxt  = COLLECT;
        credit_nxt = ZERO_C;
      end
    endcase
  end

  // State, credit, counter and Moore outputs, all registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      credit      <= ZERO_C;
      sold_count  <= '0;
      coin_reject <= 1'b0;
      newspaper   <= 1'b0;
      change_n    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      coin_reject <= coin_bad;
      newspaper   <= (state_nxt == DISPENSE);
      change_n    <= (state_nxt == CHANGE);
      busy        <= (state_nxt != COLLECT);
      if (sale) sold_count <= sat_inc(sold_count);
    end
  end

endmodule
